// File: rtl/imem_uart_loader.sv
// ============================================================================
//  Module   : imem_uart_loader
//  Purpose  : Loads a program image received over an 8N1 UART into
//             instruction memory and holds the CPU in reset until it is done.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_uart_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          IMEM_WORDS   = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(IMEM_WORDS + 1);

  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]      c_capacity  = 32'(IMEM_WORDS);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [2:0] L_LEN0 = 3'd0;
  localparam logic [2:0] L_LEN1 = 3'd1;
  localparam logic [2:0] L_DATA = 3'd2;
  localparam logic [2:0] L_DONE = 3'd3;
  localparam logic [2:0] L_ERR  = 3'd4;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic [2:0]       r_rx_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_rx_byte;
  logic             r_byte_valid;
  logic             r_frame_err;

  logic [2:0]       r_ld_state;
  logic [15:0]      r_count;
  logic [IDX_W-1:0] r_index;
  logic [1:0]       r_byte_sel;
  logic [31:0]      r_word;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;

  logic [15:0]      w_len;
  logic [31:0]      w_index_ext;

  assign w_len       = {r_rx_byte, r_count[7:0]};
  assign w_index_ext = 32'(r_index);

  // Synchronizer idles high so a reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state   <= RX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_rx_byte    <= 8'h00;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) begin
            r_rx_state <= RX_START;
            r_cnt      <= '0;
          end
        end
        RX_START: begin
          // Re-check the line half a bit in; a short glitch returns to idle.
          if (r_cnt == c_half_last) begin
            r_cnt <= '0;
            if (!r_rx_sync) begin
              r_rx_state <= RX_DATA;
              r_bit_idx  <= 3'd0;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == c_bit_last) begin
            r_cnt     <= '0;
            r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == c_bit_last) begin
            r_cnt <= '0;
            if (r_rx_sync) begin
              r_byte_valid <= 1'b1;
              r_rx_state   <= RX_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_rx_state  <= RX_WAIT;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (r_rx_sync) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ld_state <= L_LEN0;
      r_count    <= 16'h0000;
      r_index    <= '0;
      r_byte_sel <= 2'd0;
      r_word     <= 32'h0;
      r_we       <= 1'b0;
      r_addr     <= 32'h0;
      r_data     <= 32'h0;
    end else begin
      r_we <= 1'b0;
      case (r_ld_state)
        L_LEN0: begin
          if (r_frame_err) begin
            r_ld_state <= L_ERR;
          end else if (r_byte_valid) begin
            r_count[7:0] <= r_rx_byte;
            r_ld_state   <= L_LEN1;
          end
        end
        L_LEN1: begin
          if (r_frame_err) begin
            r_ld_state <= L_ERR;
          end else if (r_byte_valid) begin
            r_count <= w_len;
            if (w_len == 16'h0000) begin
              r_ld_state <= L_DONE;
            end else if ({16'h0000, w_len} > c_capacity) begin
              r_ld_state <= L_ERR;
            end else begin
              r_ld_state <= L_DATA;
              r_index    <= '0;
              r_byte_sel <= 2'd0;
            end
          end
        end
        L_DATA: begin
          if (r_frame_err) begin
            r_ld_state <= L_ERR;
          end else if (r_we && (w_index_ext == {16'h0000, r_count})) begin
            // Index was bumped with the strobe, so this is the final word.
            r_ld_state <= L_DONE;
          end else if (r_byte_valid) begin
            r_word     <= {r_rx_byte, r_word[31:8]};
            r_byte_sel <= r_byte_sel + 2'd1;
            if (r_byte_sel == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= BASE_ADDR + (w_index_ext << 2);
              r_data  <= {r_rx_byte, r_word[31:8]};
              r_index <= r_index + 1'b1;
            end
          end
        end
        L_DONE: r_ld_state <= L_DONE;
        L_ERR:  r_ld_state <= L_ERR;
        default: r_ld_state <= L_ERR;
      endcase
    end
  end

  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_data   = r_data;
  assign load_done   = (r_ld_state == L_DONE);
  assign cpu_reset_n = (r_ld_state == L_DONE);
  assign load_err    = (r_ld_state == L_ERR);

endmodule

`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
// ============================================================================
//  Module   : tb_imem_uart_loader
//  Purpose  : Self-checking bench for imem_uart_loader (two instances with
//             different base address and capacity share one serial line).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_uart_loader;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic uart_rx = 1'b1;

  logic        a_we, a_cpu, a_done, a_err;
  logic [31:0] a_addr, a_data;
  logic        b_we, b_cpu, b_done, b_err;
  logic [31:0] b_addr, b_data;

  always #5 clk = ~clk;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .IMEM_WORDS(256)) dut_a (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .imem_we(a_we), .imem_addr(a_addr), .imem_data(a_data),
    .cpu_reset_n(a_cpu), .load_done(a_done), .load_err(a_err)
  );

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h100), .IMEM_WORDS(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx),
    .imem_we(b_we), .imem_addr(b_addr), .imem_data(b_data),
    .cpu_reset_n(b_cpu), .load_done(b_done), .load_err(b_err)
  );

  typedef struct {
    int           n;
    logic [127:0] b;         // byte 0 in the top bits
    logic [15:0]  bad;       // bit i: byte i sent with a low stop bit
    bit           done;
    bit           err;
    int           nwr;
    logic [31:0]  last_addr;
    logic [31:0]  last_data;
  } vec_t;

  vec_t        tbl[8];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] got_a[$];
  logic [63:0] got_b[$];
  logic [63:0] exp_q[$];
  logic [7:0]  stim_b[$];
  bit          stim_bad[$];

  always @(negedge clk) begin
    if (a_we) got_a.push_back({a_addr, a_data});
    if (b_we) got_b.push_back({b_addr, b_data});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = !bad;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    got_a.delete();
    got_b.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_stim();
    for (int i = 0; i < stim_b.size(); i++) send_byte(stim_b[i], stim_bad[i]);
    repeat (20) @(negedge clk);
  endtask

  // Reference: walk the byte stream with the loader's rules at byte level.
  task automatic model(input int cap, input logic [31:0] base, output bit done, output bit err);
    int          good;
    int          cnt;
    int          idx;
    logic [31:0] w;
    exp_q.delete();
    done = 0; err = 0; good = 0; cnt = 0; idx = 0; w = 32'h0;
    for (int i = 0; i < stim_b.size(); i++) begin
      if (done || err) continue;
      if (stim_bad[i]) begin
        err = 1;
        continue;
      end
      if (good == 0) begin
        cnt = int'(stim_b[i]);
      end else if (good == 1) begin
        cnt = cnt + 256 * int'(stim_b[i]);
        if (cnt == 0) done = 1;
        else if (cnt > cap) err = 1;
      end else begin
        w[((good - 2) % 4) * 8 +: 8] = stim_b[i];
        if ((good - 2) % 4 == 3) begin
          exp_q.push_back({base + 32'(4 * idx), w});
          idx++;
          if (idx == cnt) done = 1;
        end
      end
      good++;
    end
  endtask

  task automatic compare_model(input string tag);
    bit d, e;
    model(256, 32'h0, d, e);
    check({tag, " a nwr"}, 64'(got_a.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++)
      check($sformatf("%s a wr%0d", tag, i), got_a[i], exp_q[i]);
    check({tag, " a done"}, 64'(a_done), 64'(d));
    check({tag, " a err"}, 64'(a_err), 64'(e));
    check({tag, " a cpu_rst_n"}, 64'(a_cpu), 64'(d));
    model(3, 32'h100, d, e);
    check({tag, " b nwr"}, 64'(got_b.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++)
      check($sformatf("%s b wr%0d", tag, i), got_b[i], exp_q[i]);
    check({tag, " b done"}, 64'(b_done), 64'(d));
    check({tag, " b err"}, 64'(b_err), 64'(e));
    check({tag, " b cpu_rst_n"}, 64'(b_cpu), 64'(d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{10, 128'h0200_1305_1000_9305_2000_0000_0000_0000, 16'h0000, 1'b1, 1'b0, 2, 32'h4, 32'h0020_0593};
    tbl[1] = '{6,  128'h0100_EFBE_ADDE_0000_0000_0000_0000_0000, 16'h0000, 1'b1, 1'b0, 1, 32'h0, 32'hDEAD_BEEF};
    tbl[2] = '{2,  128'h0000_0000_0000_0000_0000_0000_0000_0000, 16'h0000, 1'b1, 1'b0, 0, 32'h0, 32'h0};
    tbl[3] = '{2,  128'h0101_0000_0000_0000_0000_0000_0000_0000, 16'h0000, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    tbl[4] = '{9,  128'h0200_1122_3344_5566_7700_0000_0000_0000, 16'h0100, 1'b0, 1'b1, 1, 32'h0, 32'h4433_2211};
    tbl[5] = '{7,  128'h0100_7856_3412_FF00_0000_0000_0000_0000, 16'h0040, 1'b1, 1'b0, 1, 32'h0, 32'h1234_5678};
    tbl[6] = '{14, 128'h0300_0102_0304_0506_0708_090A_0B0C_0000, 16'h0000, 1'b1, 1'b0, 3, 32'h8, 32'h0C0B_0A09};
    tbl[7] = '{1,  128'h0500_0000_0000_0000_0000_0000_0000_0000, 16'h0001, 1'b0, 1'b1, 0, 32'h0, 32'h0};

    // Reset state, observed while reset is still asserted.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst we",    64'(a_we),   64'(0));
    check("rst addr",  64'(a_addr), 64'(0));
    check("rst data",  64'(a_data), 64'(0));
    check("rst cpu",   64'(a_cpu),  64'(0));
    check("rst done",  64'(a_done), 64'(0));
    check("rst err",   64'(a_err),  64'(0));

    for (int k = 0; k < 8; k++) begin
      stim_b.delete();
      stim_bad.delete();
      for (int i = 0; i < tbl[k].n; i++) begin
        stim_b.push_back(tbl[k].b[127 - 8 * i -: 8]);
        stim_bad.push_back(tbl[k].bad[i]);
      end
      do_reset();
      run_stim();
      check($sformatf("v%0d nwr", k),  64'(got_a.size()), 64'(tbl[k].nwr));
      check($sformatf("v%0d done", k), 64'(a_done), 64'(tbl[k].done));
      check($sformatf("v%0d err", k),  64'(a_err),  64'(tbl[k].err));
      check($sformatf("v%0d cpu", k),  64'(a_cpu),  64'(tbl[k].done));
      check($sformatf("v%0d addr", k), 64'(a_addr), 64'(tbl[k].last_addr));
      check($sformatf("v%0d data", k), 64'(a_data), 64'(tbl[k].last_data));
      compare_model($sformatf("v%0d", k));
    end

    // Randomized images, including extra trailing bytes and stray framing errors.
    for (int r = 0; r < 6; r++) begin
      int cnt;
      int extra;
      stim_b.delete();
      stim_bad.delete();
      cnt = $urandom_range(0, 4);
      stim_b.push_back(8'(cnt)); stim_bad.push_back(1'b0);
      stim_b.push_back(8'h00);   stim_bad.push_back(1'b0);
      extra = $urandom_range(0, 2);
      for (int i = 0; i < 4 * cnt + extra; i++) begin
        stim_b.push_back(8'($urandom));
        stim_bad.push_back(1'b0);
      end
      if ($urandom_range(0, 3) == 0) stim_bad[$urandom_range(0, stim_b.size() - 1)] = 1'b1;
      do_reset();
      run_stim();
      compare_model($sformatf("rnd%0d", r));
    end

    // Zero-length image: release happens right after the second stop bit.
    do_reset();
    send_byte(8'h00, 1'b0);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    check("zl done before stop", 64'(a_done), 64'(0));
    check("zl cpu before stop",  64'(a_cpu),  64'(0));
    repeat (CPB + 4) @(negedge clk);
    check("zl done after stop", 64'(a_done), 64'(1));
    check("zl cpu after stop",  64'(a_cpu),  64'(1));
    check("zl no writes",       64'(got_a.size()), 64'(0));

    // Idle glitch, partial word, asynchronous reset mid-word, then reload.
    do_reset();
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    stim_b = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    stim_bad = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_stim();
    check("gl err",    64'(a_err),  64'(0));
    check("gl done",   64'(a_done), 64'(0));
    check("gl writes", 64'(got_a.size()), 64'(0));
    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    got_a.delete();
    got_b.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    stim_b = '{8'h01, 8'h00, 8'h67, 8'h45, 8'h23, 8'h01};
    stim_bad = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_stim();
    check("rl a write", got_a.size() > 0 ? got_a[0] : 64'hX, {32'h0, 32'h0123_4567});
    check("rl b write", got_b.size() > 0 ? got_b[0] : 64'hX, {32'h100, 32'h0123_4567});
    compare_model("reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer side of the instruction-memory load port that the CPU top reads through its tb_addr/tb_inst inputs.
- Receives a program image over a UART line (8N1) and assembles bytes into 32-bit little-endian words.
- Issues one write strobe per word with a byte address and instruction word.
- Holds the CPU in reset until the whole image is written, then releases it.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (min 4, e.g. 100 MHz/115200)
BASE_ADDR, 32'h0000_0000, byte address of the first word written
IMEM_WORDS, 256, instruction memory capacity in words; larger images are rejected

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
uart_rx  input  1  serial line, idle high, asynchronous to clk
imem_we  output  1  one-cycle write strobe for instruction memory
imem_addr  output  32  byte address of the word being written (drives tb_addr)
imem_data  output  32  instruction word being written (drives tb_inst)
cpu_reset_n  output  1  active-low reset to CPU; 0 until load completes
load_done  output  1  high once the image is fully written
load_err  output  1  sticky error: framing error or oversize length

Behaviour:
- Reset: all outputs 0 (cpu_reset_n=0, imem_we=0, imem_addr=0, imem_data=0, load_done=0, load_err=0). Synchronizer flops reset to 1; both FSMs go to idle. Asserting reset_n low mid-operation aborts everything and discards partial bytes/words.
- Input sync: uart_rx passes through a 2-flop synchronizer before any use.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT.
  - RX_IDLE -> RX_START on synced line 0.
  - RX_START: sample at CLKS_PER_BIT/2 (integer division). If 0 -> RX_DATA. If 1 (glitch) -> RX_IDLE, no error.
  - RX_DATA: 8 samples, one every CLKS_PER_BIT cycles, LSB first.
  - RX_STOP: sample after a further CLKS_PER_BIT. If 1 -> internal 1-cycle byte_valid pulse, then RX_IDLE. If 0 -> framing error, byte discarded, RX_WAIT.
  - RX_WAIT: wait until the line is 1, then RX_IDLE.
- Load FSM states: L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR.
  - L_LEN0: first byte = word count bits [7:0].
  - L_LEN1: second byte = count bits [15:8].
  - After L_LEN1: count 0 -> L_DONE. Count > IMEM_WORDS -> L_ERR. Otherwise -> L_DATA with word index 0.
  - L_DATA: bytes fill the word little-endian (byte 0 -> [7:0] ... byte 3 -> [31:24]).
  - On the cycle after the 4th byte's byte_valid, imem_we=1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*index and imem_data = the assembled word.
  - The index increments after each write. After the write of word count-1 -> L_DONE.
  - imem_addr/imem_data hold their last values between strobes.
  - L_DONE: load_done=1 and cpu_reset_n=1 from the first cycle in L_DONE. Further UART bytes are ignored and no writes occur.
  - A framing error in any state except L_DONE -> L_ERR: load_err=1, cpu_reset_n stays 0, no further writes. Framing errors in L_DONE are ignored.
  - L_ERR is terminal; exit only via reset_n.
- No back-pressure: memory accepts the write in the strobe cycle. Worst-case byte spacing (10*CLKS_PER_BIT) exceeds the write latency, so bytes are never dropped.
- Index width is $clog2(IMEM_WORDS+1). Address arithmetic is 32-bit modulo.

Test Plan:
- CLKS_PER_BIT=4, send 02 00 13 05 10 00 93 05 20 00 -> imem_we pulses twice: (addr 0x0, data 0x00100513), (addr 0x4, data 0x00200593). Then load_done=1, cpu_reset_n=1, load_err=0.
- BASE_ADDR=32'h100, count 1, word bytes EF BE AD DE -> single write: addr 0x100, data 0xDEADBEEF.
- Length bytes 00 00 -> no imem_we; load_done=1 and cpu_reset_n=1 one cycle after the second byte's stop bit is accepted.
- IMEM_WORDS=256, length bytes 01 01 (257) -> load_err=1, no writes, cpu_reset_n stays 0.
- Count 2; stop bit of byte 3 forced low -> load_err=1, exactly one write (word 0), cpu_reset_n=0.
- 1-cycle low glitch on uart_rx while idle -> no byte accepted. Then drive reset_n low mid-word and reload a 1-word image -> write at addr BASE_ADDR with the correct data.
